// File: rtl/mpu_context_loader.sv
// Context-switch sequencer: fetches four protection words for a pid from the
// process table and writes them into the MPU. Optional validation under MPU_CTX_CHECK_EN.
module mpu_context_loader #(
    parameter int PID_W = 4
) (
    input  logic               i_clock,
    input  logic               i_reset,
    input  logic               i_start,
    input  logic [PID_W-1:0]   i_pid,
    output logic               o_busy,
    output logic               o_done,
    output logic               o_error,
    output logic [PID_W-1:0]   o_cur_pid,
    output logic               o_tbl_rd,
    output logic [PID_W+1:0]   o_tbl_addr,
    input  logic [31:0]        i_tbl_rdata,
    output logic               o_mpu_we,
    output logic [1:0]         o_mpu_addr,
    output logic [31:0]        o_mpu_wdata
);

    typedef enum logic [2:0] {
        S_IDLE, S_READ, S_CAPTURE, S_CHECK, S_WRITE, S_DONE
    } state_t;

    state_t             r_state;
    logic [1:0]         r_idx;
    logic [PID_W-1:0]   r_pid_q;
    logic               r_err_q;
    logic [31:0]        r_buf [4];
    logic               r_busy;
    logic               r_done;
    logic [PID_W-1:0]   r_cur_pid;
    logic               r_tbl_rd;
    logic [PID_W+1:0]   r_tbl_addr;
    logic               r_mpu_we;
    logic [1:0]         r_mpu_addr;
    logic [31:0]        r_mpu_wdata;
    logic               w_check_fail;

`ifdef MPU_CTX_CHECK_EN
    logic w_inst_carry;
    logic w_data_carry;
    logic r_error;

    // a + b carries out of 32 bits exactly when a > ~b
    assign w_inst_carry = (r_buf[0] > ~r_buf[1]);
    assign w_data_carry = (r_buf[2] > ~r_buf[3]);
    assign w_check_fail = (r_buf[1] == 32'd0) || (r_buf[3] == 32'd0)
                        || w_inst_carry || w_data_carry;

    always_ff @(posedge i_clock) begin
        if (i_reset) r_error <= 1'b0;
        else         r_error <= (r_state == S_CHECK) && w_check_fail;
    end
    assign o_error = r_error;
`else
    assign w_check_fail = 1'b0;
    assign o_error      = 1'b0;
`endif

    // NOTE: r_buf is a data-only buffer, always refilled before use, so it is
    // deliberately left out of reset; everything else is state and is reset.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state     <= S_IDLE;
            r_idx       <= 2'd0;
            r_pid_q     <= '0;
            r_err_q     <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_cur_pid   <= '0;
            r_tbl_rd    <= 1'b0;
            r_tbl_addr  <= '0;
            r_mpu_we    <= 1'b0;
            r_mpu_addr  <= 2'd0;
            r_mpu_wdata <= 32'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_pid_q    <= i_pid;
                        r_idx      <= 2'd0;
                        r_busy     <= 1'b1;
                        r_tbl_rd   <= 1'b1;
                        r_tbl_addr <= {i_pid, 2'd0};
                        r_state    <= S_READ;
                    end
                end
                S_READ: begin
                    // data for the previous read index arrives this cycle
                    if (r_idx != 2'd0) r_buf[r_idx - 2'd1] <= i_tbl_rdata;
                    if (r_idx == 2'd3) begin
                        r_tbl_rd   <= 1'b0;
                        r_tbl_addr <= '0;
                        r_state    <= S_CAPTURE;
                    end else begin
                        r_idx      <= r_idx + 2'd1;
                        r_tbl_addr <= {r_pid_q, r_idx + 2'd1};
                    end
                end
                S_CAPTURE: begin
                    r_buf[3] <= i_tbl_rdata;
                    r_state  <= S_CHECK;
                end
                S_CHECK: begin
                    if (w_check_fail) begin
                        r_err_q <= 1'b1;
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end else begin
                        r_idx       <= 2'd0;
                        r_mpu_we    <= 1'b1;
                        r_mpu_addr  <= 2'd0;
                        r_mpu_wdata <= r_buf[0];
                        r_state     <= S_WRITE;
                    end
                end
                S_WRITE: begin
                    if (r_idx == 2'd3) begin
                        r_mpu_we    <= 1'b0;
                        r_mpu_addr  <= 2'd0;
                        r_mpu_wdata <= 32'd0;
                        r_done      <= 1'b1;
                        r_state     <= S_DONE;
                    end else begin
                        r_idx       <= r_idx + 2'd1;
                        r_mpu_addr  <= r_idx + 2'd1;
                        r_mpu_wdata <= r_buf[r_idx + 2'd1];
                    end
                end
                S_DONE: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    if (!r_err_q) r_cur_pid <= r_pid_q;
                    r_err_q <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign o_busy      = r_busy;
    assign o_done      = r_done;
    assign o_cur_pid   = r_cur_pid;
    assign o_tbl_rd    = r_tbl_rd;
    assign o_tbl_addr  = r_tbl_addr;
    assign o_mpu_we    = r_mpu_we;
    assign o_mpu_addr  = r_mpu_addr;
    assign o_mpu_wdata = r_mpu_wdata;

endmodule

// File: tb/tb_mpu_context_loader.sv
// Directed bench for mpu_context_loader; expected per-cycle output vectors are
// hand-derived from the cycle timeline T+1..T+12 (fail path T+1..T+8).
module tb_mpu_context_loader;

    logic        clk;
    logic        rst;
    logic        i_start;
    logic [3:0]  i_pid;
    logic        o_busy, o_done, o_error, o_tbl_rd, o_mpu_we;
    logic [3:0]  o_cur_pid;
    logic [5:0]  o_tbl_addr;
    logic [31:0] tbl_rdata;
    logic [1:0]  o_mpu_addr;
    logic [31:0] o_mpu_wdata;

    logic [31:0] tbl_mem [64];
    int          vectors;
    int          miscompares;
    logic [3:0]  exp_cur_pid;

    mpu_context_loader #(.PID_W(4)) dut (
        .i_clock     (clk),
        .i_reset     (rst),
        .i_start     (i_start),
        .i_pid       (i_pid),
        .o_busy      (o_busy),
        .o_done      (o_done),
        .o_error     (o_error),
        .o_cur_pid   (o_cur_pid),
        .o_tbl_rd    (o_tbl_rd),
        .o_tbl_addr  (o_tbl_addr),
        .i_tbl_rdata (tbl_rdata),
        .o_mpu_we    (o_mpu_we),
        .o_mpu_addr  (o_mpu_addr),
        .o_mpu_wdata (o_mpu_wdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Process table: data valid the cycle after the read strobe
    always @(posedge clk) if (o_tbl_rd) tbl_rdata <= tbl_mem[o_tbl_addr];

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [48:0] observed();
        return {o_busy, o_done, o_error, o_tbl_rd, o_tbl_addr, o_mpu_we,
                o_mpu_addr, o_mpu_wdata, o_cur_pid};
    endfunction

    // Expected outputs k cycles after acceptance (k = 12, or 8 on fail, is idle)
    function automatic logic [48:0] exp_vec(input int k, input logic [3:0] p,
                                            input logic [31:0] w0, w1, w2, w3,
                                            input bit fail, input logic [3:0] prev);
        logic [31:0] w [4];
        logic        busy, done, err, rd, we;
        logic [5:0]  addr;
        logic [1:0]  ma;
        logic [31:0] wd;
        logic [3:0]  cur;
        w[0] = w0; w[1] = w1; w[2] = w2; w[3] = w3;
        rd   = (k >= 1) && (k <= 4);
        addr = rd ? {p, 2'(k - 1)} : 6'd0;
        if (fail) begin
            busy = (k <= 7); done = (k == 7); err = (k == 7); we = 1'b0; cur = prev;
        end else begin
            busy = (k <= 11); done = (k == 11); err = 1'b0;
            we   = (k >= 7) && (k <= 10);
            cur  = (k == 12) ? p : prev;
        end
        ma = we ? 2'(k - 7) : 2'd0;
        wd = we ? w[2'(k - 7)] : 32'd0;
        return {busy, done, err, rd, addr, we, ma, wd, cur};
    endfunction

    task automatic do_load(input string name, input logic [3:0] p,
                           input logic [31:0] w0, w1, w2, w3,
                           input bit fail, input int ign_k);
        int          last;
        logic [48:0] exp;
        logic [48:0] obs;
        tbl_mem[{p, 2'd0}] = w0;
        tbl_mem[{p, 2'd1}] = w1;
        tbl_mem[{p, 2'd2}] = w2;
        tbl_mem[{p, 2'd3}] = w3;
        last = fail ? 8 : 12;
        i_start = 1'b1;
        i_pid   = p;
        tick();
        i_start = 1'b0;
        for (int k = 1; k <= last; k++) begin
            exp = exp_vec(k, p, w0, w1, w2, w3, fail, exp_cur_pid);
            obs = observed();
            vectors++;
            if (obs !== exp) begin
                miscompares++;
                $display("FAIL %s T+%0d got=%h exp=%h", name, k, obs, exp);
            end
            if (k == ign_k) begin
                i_start = 1'b1;
                i_pid   = 4'd5;
            end
            if (k < last) tick();
            i_start = 1'b0;
        end
        if (!fail) exp_cur_pid = p;
    endtask

    task automatic test_reset();
        rst = 1'b1; i_start = 1'b0; i_pid = 4'd0;
        tick(); tick();
        vectors++;
        if (observed() !== 49'd0) begin
            miscompares++;
            $display("FAIL reset_state got=%h exp=%h", observed(), 49'd0);
        end
        rst = 1'b0;
        tick();
        exp_cur_pid = 4'd0;
    endtask

    task automatic test_basic();
        do_load("basic_pid3", 4'd3, 32'h1000, 32'h0400, 32'h8000, 32'h0200, 1'b0, 0);
    endtask

    task automatic test_ignore_start();
        tbl_mem[{4'd5, 2'd0}] = 32'hDEAD_0000;
        do_load("ignore_start", 4'd3, 32'h1000, 32'h0400, 32'h8000, 32'h0200, 1'b0, 3);
        do_load("next_after_ignore", 4'd5, 32'h2000, 32'h0100, 32'h4000, 32'h0080, 1'b0, 0);
    endtask

    task automatic test_check();
`ifdef MPU_CTX_CHECK_EN
        do_load("chk_limit_zero", 4'd2, 32'h0100, 32'h0, 32'h0200, 32'h0010, 1'b1, 0);
        do_load("chk_data_carry", 4'd2, 32'h1000, 32'h0400, 32'hFFFF_F000, 32'h2000, 1'b1, 0);
`else
        do_load("nochk_limit_zero", 4'd2, 32'h0100, 32'h0, 32'h0200, 32'h0010, 1'b0, 0);
`endif
    endtask

    task automatic test_reset_mid();
        logic [48:0] exp;
        tbl_mem[{4'd6, 2'd0}] = 32'h0000_6000;
        tbl_mem[{4'd6, 2'd1}] = 32'h0000_0600;
        tbl_mem[{4'd6, 2'd2}] = 32'h0006_0000;
        tbl_mem[{4'd6, 2'd3}] = 32'h0000_0060;
        i_start = 1'b1; i_pid = 4'd6;
        tick();
        i_start = 1'b0;
        repeat (7) tick();
        exp = exp_vec(8, 4'd6, 32'h6000, 32'h0600, 32'h60000, 32'h0060, 1'b0, exp_cur_pid);
        vectors++;
        if (observed() !== exp) begin
            miscompares++;
            $display("FAIL reset_mid_T+8 got=%h exp=%h", observed(), exp);
        end
        rst = 1'b1;
        tick();
        exp_cur_pid = 4'd0;
        vectors++;
        if (observed() !== 49'd0) begin
            miscompares++;
            $display("FAIL reset_mid_clear got=%h exp=%h", observed(), 49'd0);
        end
        rst = 1'b0;
        do_load("after_reset", 4'd6, 32'h6000, 32'h0600, 32'h60000, 32'h0060, 1'b0, 0);
    endtask

    task automatic test_back_to_back();
        logic [48:0] exp;
        tbl_mem[{4'd1, 2'd0}] = 32'h0001_0000; tbl_mem[{4'd1, 2'd1}] = 32'h0000_1000;
        tbl_mem[{4'd1, 2'd2}] = 32'h0002_0000; tbl_mem[{4'd1, 2'd3}] = 32'h0000_2000;
        tbl_mem[{4'd2, 2'd0}] = 32'h0003_0000; tbl_mem[{4'd2, 2'd1}] = 32'h0000_3000;
        tbl_mem[{4'd2, 2'd2}] = 32'h0004_0000; tbl_mem[{4'd2, 2'd3}] = 32'h0000_4000;
        i_start = 1'b1; i_pid = 4'd1;
        tick();
        i_pid = 4'd2;
        for (int k = 1; k <= 12; k++) begin
            exp = exp_vec(k, 4'd1, 32'h10000, 32'h1000, 32'h20000, 32'h2000, 1'b0, exp_cur_pid);
            vectors++;
            if (observed() !== exp) begin
                miscompares++;
                $display("FAIL b2b_first T+%0d got=%h exp=%h", k, observed(), exp);
            end
            tick();
        end
        i_start = 1'b0;
        exp_cur_pid = 4'd1;
        for (int k = 1; k <= 12; k++) begin
            exp = exp_vec(k, 4'd2, 32'h30000, 32'h3000, 32'h40000, 32'h4000, 1'b0, exp_cur_pid);
            vectors++;
            if (observed() !== exp) begin
                miscompares++;
                $display("FAIL b2b_second T+%0d got=%h exp=%h", k + 12, observed(), exp);
            end
            if (k < 12) tick();
        end
        exp_cur_pid = 4'd2;
    endtask

    task automatic test_reset_with_start();
        rst = 1'b1; i_start = 1'b1; i_pid = 4'd7;
        tick();
        rst = 1'b0; i_start = 1'b0;
        exp_cur_pid = 4'd0;
        vectors++;
        if (observed() !== 49'd0) begin
            miscompares++;
            $display("FAIL reset_with_start got=%h exp=%h", observed(), 49'd0);
        end
        tick();
        vectors++;
        if (observed() !== 49'd0) begin
            miscompares++;
            $display("FAIL reset_start_dropped got=%h exp=%h", observed(), 49'd0);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        tbl_rdata   = 32'd0;
        for (int i = 0; i < 64; i++) tbl_mem[i] = 32'd0;
        test_reset();
        test_basic();
        test_ignore_start();
        test_check();
        test_reset_mid();
        test_back_to_back();
        test_reset_with_start();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
